mux_rr_n: RTL and testbench

- Parametrised, registered N-channel successor to the 16-bit 2:1 datapath mux.
- Selects one of NCH WIDTH-bit input channels and forwards it through one output register stage, with valid/ready handshakes on every channel.
- Two selection modes:
  - fixed: external select.
  - round-robin: fair arbitration across requesting channels.
- Sits between ALU operand sources and downstream consumers that can stall.

---
 rtl/alu_pkg.sv | 14 +
 rtl/mux_rr_n_rr_pick.sv | 29 ++
 rtl/mux_rr_n.sv | 85 ++++++++
 tb/tb_mux_rr_n.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared mode encodings and sizing helper for the datapath muxes
package alu_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_n_rr_pick.sv
// rtl/mux_rr_n_rr_pick.sv - rotated-priority picker: first requester at or after ptr, wrapping
module rr_pick
  import alu_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    int k;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    k         = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NCH;
      if (req[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SELW'(k);
      end
    end
  end

endmodule

// File: rtl/mux_rr_n.sv
// rtl/mux_rr_n.sv - registered N-channel mux with fixed or round-robin selection
module mux_rr_n
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr;
  logic             load;
  logic             fix_valid;
  logic             rr_valid;
  logic [SELW-1:0]  rr_idx;
  logic             gnt_valid;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer;

  rr_pick #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_pick (
    .req       (in_valid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  assign load = !out_valid || out_ready;

  // sel may exceed NCH-1 when NCH is not a power of two; such values never grant.
  always_comb begin
    fix_valid = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k)) fix_valid = in_valid[k];
    end
  end

  assign gnt_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
  assign gnt_idx   = (mode == MODE_RR) ? rr_idx : sel;
  assign xfer      = rst_n && load && gnt_valid;

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_idx == SELW'(k)) begin
        in_ready[k] = xfer;
        gnt_data    = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_chan  <= gnt_idx;
      if (mode == MODE_RR) begin
        ptr <= (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_n.sv
// tb/tb_mux_rr_n.sv - scoreboard bench for mux_rr_n against a behavioural model
module tb_mux_rr_n;

  localparam int WIDTH = 16;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_chan;
  logic                 out_valid;
  logic                 out_ready;

  // NCH=3 instance to exercise an unused select code.
  logic [1:0]           sel3;
  logic [3*WIDTH-1:0]   in_data3;
  logic [2:0]           in_valid3;
  logic [2:0]           in_ready3;
  logic [WIDTH-1:0]     out_data3;
  logic [1:0]           out_chan3;
  logic                 out_valid3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int               chan;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t q[$];
  bit   m_valid = 0;
  int   m_ptr   = 0;

  always #5 clk = ~clk;

  mux_rr_n #(.WIDTH(WIDTH), .NCH(NCH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_rr_n #(.WIDTH(WIDTH), .NCH(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (1'b0),
    .sel       (sel3),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_chan  (out_chan3),
    .out_valid (out_valid3),
    .out_ready (1'b1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] chan_data(input int k);
    return in_data[k*WIDTH +: WIDTH];
  endfunction

  // Monitor: a word leaves the output stage whenever valid and ready meet at an edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_pop", {48'h0, out_data}, 64'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pop_data", {48'h0, out_data}, {48'h0, e.data});
        chk("pop_chan", {62'h0, out_chan}, e.chan);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("nch3_in_ready", {61'h0, in_ready3}, 64'h0);
      chk("nch3_out_valid", {63'h0, out_valid3}, 64'h0);
    end
  end

  // Reference model: decide this cycle's grant from the rules, then advance one edge.
  task automatic step();
    bit               gv;
    int               k;
    bit               ld;
    logic [NCH-1:0]   exp_rdy;
    exp_t             e;
    #1;
    gv = 0;
    k  = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < NCH && in_valid[sel]) begin
        gv = 1;
        k  = int'(sel);
      end
    end else begin
      for (int off = 0; off < NCH; off++) begin
        if (!gv && in_valid[(m_ptr + off) % NCH]) begin
          gv = 1;
          k  = (m_ptr + off) % NCH;
        end
      end
    end
    ld      = !m_valid || out_ready;
    exp_rdy = (rst_n && gv && ld) ? NCH'(1 << k) : '0;
    chk("in_ready", {60'h0, in_ready}, {60'h0, exp_rdy});
    chk("out_valid", {63'h0, out_valid}, {63'h0, m_valid});
    if (!rst_n) begin
      q.delete();
      m_valid = 0;
      m_ptr   = 0;
    end else if (gv && ld) begin
      e.chan = k;
      e.data = chan_data(k);
      q.push_back(e);
      m_valid = 1;
      if (mode) m_ptr = (k + 1) % NCH;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_out_data", {48'h0, out_data}, 64'h0);
    chk("rst_out_chan", {62'h0, out_chan}, 64'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    sel3      = 2'd3;
    in_data3  = {16'h3333, 16'h2222, 16'h1111};
    in_valid3 = 3'b111;
    @(posedge clk);
    #1;

    // Reset, fixed select, stall and release
    step();
    step();
    rst_n = 1'b1;
    chk_reset_state();
    sel      = 2'd2;
    in_data  = {16'h0, 16'hBEEF, 16'h0, 16'h0};
    in_valid = 4'b0100;
    step();
    chk("t1_data", {48'h0, out_data}, 64'hBEEF);
    chk("t1_chan", {62'h0, out_chan}, 64'd2);
    step();
    step();
    chk("t1_stall_ready", {60'h0, in_ready}, 64'h0);
    in_valid  = '0;
    out_ready = 1'b1;
    step();
    chk("t1_popped", {63'h0, out_valid}, 64'h0);

    // Round-robin fairness
    mode     = 1'b1;
    in_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t2_rr_chan", {62'h0, out_chan}, i % NCH);
      chk("t2_rr_valid", {63'h0, out_valid}, 64'h1);
    end

    // Skip and wrap
    in_valid = 4'b0100;
    step();
    chk("t3_ch2", {62'h0, out_chan}, 64'd2);
    in_valid = 4'b0010;
    step();
    chk("t3_ch1", {62'h0, out_chan}, 64'd1);
    in_valid = 4'b1001;
    step();
    chk("t3_ch3", {62'h0, out_chan}, 64'd3);
    step();
    chk("t3_ch0", {62'h0, out_chan}, 64'd0);
    in_valid = '0;
    step();

    // Fixed select on an idle channel
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b1011;
    step();
    step();
    chk("t4_idle_valid", {63'h0, out_valid}, 64'h0);

    // Simultaneous pop and load
    mode      = 1'b1;
    in_valid  = 4'b0001;
    in_data   = {16'h0, 16'h0, 16'h0, 16'hAAAA};
    out_ready = 1'b0;
    step();
    chk("t5_hold", {48'h0, out_data}, 64'hAAAA);
    in_data   = {16'h0, 16'h0, 16'h0, 16'h5555};
    out_ready = 1'b1;
    step();
    chk("t5_replace", {48'h0, out_data}, 64'h5555);
    chk("t5_valid", {63'h0, out_valid}, 64'h1);
    in_valid = '0;
    step();

    // Reset mid-operation
    in_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_reset_state();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step();
    chk("t6_first_rr", {62'h0, out_chan}, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom);
      sel       = SELW'($urandom);
      in_valid  = NCH'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(3) != 0);
      rst_n     = ($urandom_range(60) != 0);
      step();
    end

    rst_n     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("drain_queue", q.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
